// File: rtl/alu_sched_if.sv
// Bundle of requester, response and shared-ALU signals for alu_sched.
// slave  : the scheduler side (drives readys, responses and ALU inputs).
// master : the environment side (drives requests and the ALU result).
interface alu_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
    logic [3:0]  alu_control;
    logic [31:0] alu_oper1;
    logic [31:0] alu_oper2;
    logic [31:0] alu_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
        output alu_control, alu_oper1, alu_oper2
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
        input  alu_control, alu_oper1, alu_oper2
    );
endinterface

// File: rtl/alu_sched.sv
// Two-requester scheduler in front of a shared multi-cycle ALU.
// One operation in flight; round-robin arbitration when both requesters are valid.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_sched_if.slave (request handshakes, responses, ALU drive/result)
// Parameter ALU_LAT (1..15): cycles the ALU inputs are held before alu_result is sampled.
module alu_sched #(
    parameter int unsigned ALU_LAT = 2
) (
    input logic        clk,
    input logic        rst,
    alu_sched_if.slave bus
);
    localparam logic [3:0] CntInit = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        rp_q;
    logic        id_q;
    logic [31:0] rsp_result_q;
    logic        rsp_zero_q;
    logic        rsp_err_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    // The ALU drive registers double as the latched operation.
    logic [3:0]  alu_control_q;
    logic [31:0] alu_oper1_q;
    logic [31:0] alu_oper2_q;

    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        acc_legal;
    logic [3:0]  acc_op;
    logic [31:0] acc_a;
    logic [31:0] acc_b;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state_q == StIdle) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || !rp_q);
            grant1 = bus.req1_valid && (!bus.req0_valid || rp_q);
        end
        accept    = grant0 | grant1;
        acc_op    = grant1 ? bus.req1_op : bus.req0_op;
        acc_a     = grant1 ? bus.req1_a : bus.req0_a;
        acc_b     = grant1 ? bus.req1_b : bus.req0_b;
        acc_legal = (acc_op <= 4'd4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            rp_q          <= 1'b0;
            id_q          <= 1'b0;
            rsp_result_q  <= 32'd0;
            rsp_zero_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            alu_control_q <= 4'hF;
            alu_oper1_q   <= 32'd0;
            alu_oper2_q   <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        id_q <= grant1;
                        rp_q <= grant0;  // point at the requester that lost this round
                        if (acc_legal) begin
                            state_q       <= StBusy;
                            cnt_q         <= CntInit;
                            alu_control_q <= acc_op;
                            alu_oper1_q   <= acc_a;
                            alu_oper2_q   <= acc_b;
                        end else begin
                            // Illegal opcode: answer immediately without touching the ALU.
                            state_q      <= StResp;
                            rsp_result_q <= 32'd0;
                            rsp_zero_q   <= 1'b1;
                            rsp_err_q    <= 1'b1;
                            rsp0_valid_q <= grant0;
                            rsp1_valid_q <= grant1;
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q == 4'd0) begin
                        state_q       <= StResp;
                        rsp_result_q  <= bus.alu_result;
                        rsp_zero_q    <= (bus.alu_result == 32'd0);
                        rsp_err_q     <= 1'b0;
                        rsp0_valid_q  <= !id_q;
                        rsp1_valid_q  <= id_q;
                        alu_control_q <= 4'hF;
                        alu_oper1_q   <= 32'd0;
                        alu_oper2_q   <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q      <= StIdle;
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.alu_control = alu_control_q;
    assign bus.alu_oper1   = alu_oper1_q;
    assign bus.alu_oper2   = alu_oper2_q;
endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: a table of single operations plus
// hand-written sequences for reset, round-robin arbitration and reset mid-operation.
module tb_alu_sched;
    localparam int unsigned ALU_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    alu_sched_if bus ();

    alu_sched #(.ALU_LAT(ALU_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ALU model with one register stage: a result sampled too early shows the idle value.
    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] x, y);
        case (c)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x * y;
            4'd3:    return x & y;
            4'd4:    return x | y;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_ff @(posedge clk) bus.alu_result <= alu_f(bus.alu_control, bus.alu_oper1, bus.alu_oper2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_op = 4'd0;
        bus.req1_op = 4'd0;
        bus.req0_a = 32'h1111_1111;
        bus.req0_b = 32'h2222_2222;
        bus.req1_a = 32'h3333_3333;
        bus.req1_b = 32'h4444_4444;
    endtask

    // Issue one operation from requester `who`, then check handshake, latency and response.
    task automatic do_op(input bit who, input logic [3:0] op, input logic [31:0] a, b,
                         input logic [31:0] er, input bit ez, input bit ee);
        int  n;
        int  lat;
        bit  seen;
        bit  legal;
        legal = (op <= 4'd4);
        @(negedge clk);
        if (who) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        n = 0;
        while (!(who ? bus.req1_ready : bus.req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("accept_ready", 32'(who ? bus.req1_ready : bus.req0_ready), 32'd1);
        check("other_ready", 32'(who ? bus.req0_ready : bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = who ? bus.rsp1_valid : bus.rsp0_valid;
            if (legal && lat <= int'(ALU_LAT)) begin
                check("busy_alu_control", 32'(bus.alu_control), 32'(op));
                check("busy_alu_oper1", bus.alu_oper1, a);
                check("busy_alu_oper2", bus.alu_oper2, b);
                check("busy_ready0", 32'(bus.req0_ready), 32'd0);
            end else begin
                check("resp_alu_control", 32'(bus.alu_control), 32'hF);
            end
        end
        check("latency", lat, legal ? ALU_LAT + 1 : 1);
        check("rsp_result", bus.rsp_result, er);
        check("rsp_zero", 32'(bus.rsp_zero), 32'(ez));
        check("rsp_err", 32'(bus.rsp_err), 32'(ee));
        check("rsp_other_valid", 32'(who ? bus.rsp0_valid : bus.rsp1_valid), 32'd0);
        @(negedge clk);
        check("rsp_pulse_end", 32'(who ? bus.rsp1_valid : bus.rsp0_valid), 32'd0);
        check("rsp_result_hold", bus.rsp_result, er);
    endtask

    typedef struct {
        bit          who;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          zero;
        bit          err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int  g[3];
        int  ng;
        int  nrsp;
        int  nv;

        vecs[0] = '{1'b0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 4'd2, 32'h1_0000, 32'h1_0000, 32'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 4'd3, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 4'd4, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 4'd7, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 4'd15, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 4'd2, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 4'd1, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0};

        // Reset: readys stay low even with both requesters valid.
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check("rst_ready1", 32'(bus.req1_ready), 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        check("rst_alu_control", 32'(bus.alu_control), 32'hF);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk); #1;
        check("idle_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero,
                  vecs[i].err);

        // Round robin after reset: last grant above left the pointer at req1.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 4'd1; bus.req0_a = 32'd9; bus.req0_b = 32'd9;
        bus.req1_valid = 1'b1; bus.req1_op = 4'd4; bus.req1_a = 32'hF0; bus.req1_b = 32'h0F;
        ng = 0;
        nrsp = 0;
        for (int c = 0; c < 40 && ng < 3; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) check("rr_both_ready", 32'd1, 32'd0);
            if (bus.rsp0_valid) begin
                nrsp++;
                check("rr_rsp0_result", bus.rsp_result, 32'd0);
                check("rr_rsp0_zero", 32'(bus.rsp_zero), 32'd1);
            end
            if (bus.rsp1_valid) begin
                nrsp++;
                check("rr_rsp1_result", bus.rsp_result, 32'hFF);
                check("rr_rsp1_zero", 32'(bus.rsp_zero), 32'd0);
            end
            if (bus.req0_ready || bus.req1_ready) begin
                g[ng] = bus.req1_ready ? 1 : 0;
                ng++;
                if (ng == 3) begin
                    @(posedge clk); #1;
                    idle_inputs();
                end
            end
            if (ng < 3) @(negedge clk);
        end
        check("rr_grant_count", ng, 3);
        if (ng == 3) begin
            check("rr_grant0", g[0], 0);
            check("rr_grant1", g[1], 1);
            check("rr_grant2", g[2], 0);
        end
        check("rr_rsp_count", nrsp, 2);
        idle_inputs();
        repeat (6) @(negedge clk);

        // Reset during BUSY aborts the operation with no response.
        bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
        #1;
        check("abort_accept", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("abort_busy", 32'(bus.alu_control), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp0_valid || bus.rsp1_valid) nv++;
        end
        check("abort_no_rsp", nv, 0);
        check("abort_alu_control", 32'(bus.alu_control), 32'hF);
        check("abort_rsp_result", bus.rsp_result, 32'd0);
        do_op(1'b0, 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter ALU_LAT, default 2, cycles from driving alu_control/operands to sampling alu_result; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  scheduler accepts requester N's operation this cycle.
REQ-006 req0_op / req1_op  input  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-008 rsp0_valid / rsp1_valid  output  1  one-cycle pulse; response for requester N.
REQ-009 rsp_result  output  32  result of the last completed operation.
REQ-010 rsp_zero  output  1  rsp_result == 0.
REQ-011 rsp_err  output  1  last completed operation had an illegal opcode.
REQ-012 alu_control  output  4  opcode to the shared ALU.
REQ-013 alu_oper1 / alu_oper2  output  32  operands to the shared ALU.
REQ-014 alu_result  input  32  ALU result.

Function
REQ-015 FSM states: IDLE, BUSY, RESP; one operation in flight at most.
REQ-016 IDLE, no valid request: stay IDLE; both readys 0.
REQ-017 IDLE, exactly one valid: that requester's ready = 1 combinationally; the transfer completes at the same edge.
REQ-018 IDLE, both valid: grant to the requester selected by the round-robin pointer rp; only the granted ready = 1.
REQ-019 On any accept, latch op, a, b, and the requester id; set rp to the other requester.
REQ-020 Accepting a legal opcode (0..4): go to BUSY and load a counter with ALU_LAT-1.
REQ-021 Accepting an illegal opcode (5..15): go directly to RESP with rsp_result = 0, rsp_zero = 1, rsp_err = 1; the ALU is not used.
REQ-022 BUSY: drive alu_control/alu_oper1/alu_oper2 from the latched values, decrementing the counter each cycle.
REQ-023 BUSY, counter == 0: capture alu_result into rsp_result, set rsp_zero = (captured value == 0) and rsp_err = 0, then go to RESP.
REQ-024 rsp_zero is computed locally; the ALU's zero flag is not used.
REQ-025 RESP: assert rspN_valid for the latched requester for exactly one cycle, then go to IDLE.
REQ-026 Readys are 0 in BUSY and RESP.
REQ-027 A request held valid while the scheduler is busy is accepted at the next IDLE cycle.
REQ-028 Latency for a legal opcode: accept at edge T; rsp valid during cycle T+ALU_LAT+1. The next accept is possible at edge T+ALU_LAT+2.
REQ-029 Latency for an illegal opcode: rsp valid during cycle T+1.
REQ-030 Outside BUSY: alu_control = 4'hF, alu_oper1 = 0, alu_oper2 = 0.
REQ-031 rsp_result, rsp_zero and rsp_err hold their value until the next capture.
REQ-032 Requester inputs are ignored when the corresponding ready is 0.

Reset
REQ-033 With rst high at an edge: state = IDLE, rp = 0, counter = 0, rsp_result = 0, rsp_zero = 0, rsp_err = 0, both rsp_valid = 0.
REQ-034 Readys are 0 in any cycle with rst high.
REQ-035 rst asserted during BUSY or RESP aborts the in-flight operation; no response is ever issued for it.
REQ-036 After rst deasserts, the first accept goes to req0 if both requesters are valid.

Verification
REQ-037 ALU_LAT=2; req0 ADD a=5 b=7 accepted at T -> alu_control=0 during T+1..T+2; rsp0_valid at T+3; rsp_result=12, rsp_zero=0, rsp_err=0.
REQ-038 After reset, both valid continuously (req0 SUB 9-9, req1 OR 0xF0|0x0F) -> grant order req0, req1, req0; req0 response rsp_result=0, rsp_zero=1; req1 response rsp_result=0xFF.
REQ-039 req1 op=7 -> rsp1_valid one cycle after accept; rsp_result=0, rsp_zero=1, rsp_err=1; alu_control stays 4'hF throughout.
REQ-040 req0 MUL 0x10000*0x10000 -> rsp_result=0 (truncated to 32 bits), rsp_zero=1.
REQ-041 rst pulse during BUSY -> no rsp_valid; state IDLE; next request ADD 1+1 returns 2 with correct latency.
